// File: rtl/rs_age_queue_pkg.sv
// Shared types and constants for the age-ordered reservation station.
// Widths here are the defaults; the top re-derives its entry layout from its own parameters.
package rs_age_queue_pkg;

  localparam int RS_DEPTH     = 16;
  localparam int RS_NUM_CDB   = 2;
  localparam int RS_DATA_W    = 64;
  localparam int RS_TAG_W     = 41;
  localparam int RS_PAYLOAD_W = 91;
  localparam int RS_NUM_BR    = 4;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] iss_id;
    logic [3:0]  fu_id;
  } rs_tag_t;

  // Major opcodes (low 7 payload bits); every LB..LHU variant shares OPC_LOAD.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [RS_PAYLOAD_W-1:0] payload;
    logic                    op1v;
    logic [RS_DATA_W-1:0]    op1;
    logic                    op2v;
    logic [RS_DATA_W-1:0]    op2;
    logic [RS_NUM_BR-1:0]    br_mask;
    logic                    valid;
  } rs_entry_t;

  function automatic logic is_load(input logic [6:0] opcode);
    return opcode == OPC_LOAD;
  endfunction

endpackage

// File: rtl/rs_age_queue_oldest_pick.sv
// Find-first-set over the request vector: lowest index wins, reported one-hot and encoded.
module rs_oldest_pick #(
  parameter int N = 16,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_age_queue.sv
// Age-ordered reservation station: CDB wakeup, branch-mask kill/resolve, load blocking,
// oldest-ready issue and single-cycle multi-hole compaction toward index 0.
module rs_age_queue
  import rs_age_queue_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int NUM_CDB   = 2,
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 41,
  parameter int PAYLOAD_W = 91,
  parameter int NUM_BR    = 4,
  localparam int COUNTER  = $clog2(DEPTH + 1),
  localparam int BR_W     = $clog2(NUM_BR)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PAYLOAD_W-1:0]        in_payload,
  input  logic                        in_op1v,
  input  logic                        in_op2v,
  input  logic [DATA_W-1:0]           in_op1,
  input  logic [DATA_W-1:0]           in_op2,
  input  logic [NUM_BR-1:0]           in_br_mask,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
  input  logic                        br_resolve,
  input  logic                        br_kill,
  input  logic [BR_W-1:0]             br_id,
  input  logic                        flush_all,
  input  logic                        block_loads,
  output logic                        iss_valid,
  input  logic                        iss_ready,
  output logic [PAYLOAD_W-1:0]        iss_payload,
  output logic [DATA_W-1:0]           iss_op1,
  output logic [DATA_W-1:0]           iss_op2,
  output logic [COUNTER-1:0]          count,
  output logic                        empty
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic                 op1v;
    logic [DATA_W-1:0]    op1;
    logic                 op2v;
    logic [DATA_W-1:0]    op2;
    logic [NUM_BR-1:0]    br_mask;
  } ent_t;

  // Data storage is not reset; validity and occupancy are.
  ent_t               ent_q [DEPTH];
  ent_t               ent_d [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [COUNTER-1:0] count_q, count_d;

  logic [NUM_CDB-1:0] hit [DEPTH][2];
  logic [NUM_CDB-1:0] push_hit [2];
  ent_t               upd [DEPTH];
  ent_t               push_ent;
  logic [DEPTH-1:0]   elig, kill_v, remove, sel_oh;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any, fire, push;
  logic [COUNTER-1:0] keep;

  function automatic logic [NUM_CDB-1:0] tag_hit(input logic opv,
                                                 input logic [TAG_W-1:0] tag,
                                                 input logic [NUM_CDB-1:0] cv,
                                                 input logic [NUM_CDB*TAG_W-1:0] ct);
    logic [NUM_CDB-1:0] h;
    for (int c = 0; c < NUM_CDB; c++)
      h[c] = !opv && cv[c] && (ct[c*TAG_W +: TAG_W] == tag);
    return h;
  endfunction

  // Lowest-numbered matching channel supplies the data.
  function automatic logic [DATA_W-1:0] fwd_data(input logic [NUM_CDB-1:0] h,
                                                 input logic [NUM_CDB*DATA_W-1:0] cd);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--)
      if (h[c]) d = cd[c*DATA_W +: DATA_W];
    return d;
  endfunction

  // Wakeup, branch update and eligibility for stored entries.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hit[i][0] = tag_hit(ent_q[i].op1v, ent_q[i].op1[TAG_W-1:0], cdb_valid, cdb_tag);
      hit[i][1] = tag_hit(ent_q[i].op2v, ent_q[i].op2[TAG_W-1:0], cdb_valid, cdb_tag);
      upd[i] = ent_q[i];
      if (|hit[i][0]) begin
        upd[i].op1v = 1'b1;
        upd[i].op1  = fwd_data(hit[i][0], cdb_data);
      end
      if (|hit[i][1]) begin
        upd[i].op2v = 1'b1;
        upd[i].op2  = fwd_data(hit[i][1], cdb_data);
      end
      kill_v[i] = br_kill && ent_q[i].br_mask[br_id];
      if (br_resolve && !br_kill) upd[i].br_mask[br_id] = 1'b0;
      elig[i] = vld_q[i] && upd[i].op1v && upd[i].op2v && !kill_v[i] &&
                !(block_loads && is_load(ent_q[i].payload[6:0])) && !flush_all && !reset;
    end
  end

  rs_oldest_pick #(.N(DEPTH)) u_pick (
    .req   (elig),
    .grant (sel_oh),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  always_comb begin
    iss_valid   = sel_any;
    iss_payload = '0;
    iss_op1     = '0;
    iss_op2     = '0;
    if (sel_any) begin
      iss_payload = upd[sel_idx].payload;
      iss_op1     = upd[sel_idx].op1;
      iss_op2     = upd[sel_idx].op2;
    end
  end

  assign fire     = sel_any && iss_ready;
  assign in_ready = (count_q < COUNTER'(DEPTH));
  assign count    = count_q;
  assign empty    = (count_q == '0);

  // The incoming instruction snoops the CDB and sees resolve/kill in its own cycle.
  always_comb begin
    push_hit[0]      = tag_hit(in_op1v, in_op1[TAG_W-1:0], cdb_valid, cdb_tag);
    push_hit[1]      = tag_hit(in_op2v, in_op2[TAG_W-1:0], cdb_valid, cdb_tag);
    push_ent.payload = in_payload;
    push_ent.op1v    = in_op1v || (|push_hit[0]);
    push_ent.op1     = (|push_hit[0]) ? fwd_data(push_hit[0], cdb_data) : in_op1;
    push_ent.op2v    = in_op2v || (|push_hit[1]);
    push_ent.op2     = (|push_hit[1]) ? fwd_data(push_hit[1], cdb_data) : in_op2;
    push_ent.br_mask = in_br_mask;
    if (br_resolve && !br_kill) push_ent.br_mask[br_id] = 1'b0;
    push = in_valid && in_ready && !flush_all && !(br_kill && in_br_mask[br_id]);
  end

  // Compaction: each survivor moves down by the number of removed entries below it.
  always_comb begin
    ent_d = ent_q;
    vld_d = '0;
    keep  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      remove[i] = !vld_q[i] || kill_v[i] || (fire && sel_oh[i]) || flush_all;
      if (!remove[i]) begin
        ent_d[keep[IDX_W-1:0]] = upd[i];
        vld_d[keep[IDX_W-1:0]] = 1'b1;
        keep = keep + COUNTER'(1);
      end
    end
    if (push) begin
      ent_d[keep[IDX_W-1:0]] = push_ent;
      vld_d[keep[IDX_W-1:0]] = 1'b1;
    end
    count_d = keep + COUNTER'(push);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) in_valid |-> in_ready);

endmodule

// File: tb/tb_rs_age_queue.sv
// Directed bench for rs_age_queue: issue, wakeup, compaction, branch masks, load blocking, flush.
module tb_rs_age_queue;
  import rs_age_queue_pkg::*;

  localparam int DEPTH = 16, NUM_CDB = 2, DATA_W = 64, TAG_W = 41, PAYLOAD_W = 91, NUM_BR = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      in_valid, in_ready;
  logic [PAYLOAD_W-1:0]      in_payload;
  logic                      in_op1v, in_op2v;
  logic [DATA_W-1:0]         in_op1, in_op2;
  logic [NUM_BR-1:0]         in_br_mask;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic                      br_resolve, br_kill;
  logic [1:0]                br_id;
  logic                      flush_all, block_loads;
  logic                      iss_valid, iss_ready;
  logic [PAYLOAD_W-1:0]      iss_payload;
  logic [DATA_W-1:0]         iss_op1, iss_op2;
  logic [4:0]                count;
  logic                      empty;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rs_age_queue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload), .in_op1v(in_op1v), .in_op2v(in_op2v), .in_op1(in_op1),
    .in_op2(in_op2), .in_br_mask(in_br_mask), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .br_resolve(br_resolve), .br_kill(br_kill), .br_id(br_id),
    .flush_all(flush_all), .block_loads(block_loads), .iss_valid(iss_valid),
    .iss_ready(iss_ready), .iss_payload(iss_payload), .iss_op1(iss_op1), .iss_op2(iss_op2),
    .count(count), .empty(empty)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PAYLOAD_W-1:0] mk(input int id, input logic [6:0] opc);
    return {84'(id), opc};
  endfunction

  task automatic drive_push(input logic [PAYLOAD_W-1:0] p, input logic v1, input logic [63:0] o1,
                            input logic v2, input logic [63:0] o2, input logic [3:0] m);
    in_payload = p; in_op1v = v1; in_op1 = o1; in_op2v = v2; in_op2 = o2; in_br_mask = m;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_payload = '0; in_op1v = 1'b0; in_op2v = 1'b0;
    in_op1 = '0; in_op2 = '0; in_br_mask = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    br_resolve = 1'b0; br_kill = 1'b0; br_id = '0; flush_all = 1'b0; block_loads = 1'b0;
    iss_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_iss_valid", iss_valid, 0);
    check("rst_in_ready", in_ready, 1);

    // 1: ready instruction issues straight out of the entry
    drive_push(mk(1, OPC_OP), 1, 64'h11, 1, 64'h22, 4'h0);
    check("t1_iss_valid", iss_valid, 1);
    check("t1_payload", iss_payload, mk(1, OPC_OP));
    check("t1_op1", iss_op1, 64'h11);
    check("t1_count1", count, 1);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    check("t1_count0", count, 0);

    // 2: wakeup on channel 1
    drive_push(mk(2, OPC_OP), 0, 64'h5, 1, 64'h7, 4'h0);
    check("t2_wait_valid", iss_valid, 0);
    cdb_valid = 2'b10; cdb_tag[TAG_W +: TAG_W] = 41'h5; cdb_data[DATA_W +: DATA_W] = 64'hDEAD;
    #1;
    check("t2_wake_valid", iss_valid, 1);
    check("t2_wake_op1", iss_op1, 64'hDEAD);
    check("t2_wake_op2", iss_op2, 64'h7);
    step();
    cdb_valid = '0; cdb_data = '0; cdb_tag = '0;
    #1;
    check("t2_held_valid", iss_valid, 1);
    check("t2_held_op1", iss_op1, 64'hDEAD);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    check("t2_count0", count, 0);

    // 3: fill, fire entry 3 while full, then drain in age order
    for (int i = 0; i < DEPTH; i++)
      drive_push(mk(8'h30 + i, OPC_OP), (i >= 3), (i < 3) ? 64'h100 + i : 64'(i), 1, 0, 4'h0);
    check("t3_full_count", count, 16);
    check("t3_full_ready", in_ready, 0);
    check("t3_sel3", iss_payload, mk(8'h33, OPC_OP));
    iss_ready = 1'b1;
    #1;
    check("t3_ready_while_fire", in_ready, 0);
    step();
    iss_ready = 1'b0;
    check("t3_count15", count, 15);
    check("t3_ready_back", in_ready, 1);
    for (int k = 4; k < DEPTH; k++) begin
      check("t3_drain_order", iss_payload, mk(8'h30 + k, OPC_OP));
      iss_ready = 1'b1;
      step();
      iss_ready = 1'b0;
    end
    check("t3_left", count, 3);
    check("t3_left_idle", iss_valid, 0);
    cdb_valid = 2'b11; cdb_tag[0 +: TAG_W] = 41'h100; cdb_tag[TAG_W +: TAG_W] = 41'h101;
    cdb_data[0 +: DATA_W] = 64'hA0; cdb_data[DATA_W +: DATA_W] = 64'hA1;
    #1;
    check("t3_oldest_payload", iss_payload, mk(8'h30, OPC_OP));
    check("t3_oldest_op1", iss_op1, 64'hA0);
    step();
    cdb_valid = '0;
    flush_all = 1'b1;
    #1;
    check("t3_flush_iss", iss_valid, 0);
    step();
    flush_all = 1'b0;
    check("t3_flush_count", count, 0);

    // 4: branch kill compacts survivors, resolve clears masks
    drive_push(mk(8'h40, OPC_OP), 1, 1, 1, 1, 4'b0001);
    drive_push(mk(8'h41, OPC_OP), 1, 1, 1, 1, 4'b0010);
    drive_push(mk(8'h42, OPC_OP), 1, 1, 1, 1, 4'b0001);
    drive_push(mk(8'h43, OPC_OP), 1, 1, 1, 1, 4'b0000);
    br_kill = 1'b1; br_id = 2'd0;
    #1;
    check("t4_kill_sel", iss_payload, mk(8'h41, OPC_OP));
    step();
    br_kill = 1'b0;
    check("t4_kill_count", count, 2);
    check("t4_survivor0", iss_payload, mk(8'h41, OPC_OP));
    br_resolve = 1'b1; br_id = 2'd1;
    step();
    br_resolve = 1'b0; br_kill = 1'b1; br_id = 2'd1;
    step();
    br_kill = 1'b0;
    check("t4_resolved_count", count, 2);
    iss_ready = 1'b1;
    step();
    check("t4_survivor1", iss_payload, mk(8'h43, OPC_OP));
    step();
    iss_ready = 1'b0;
    check("t4_drained", count, 0);
    br_kill = 1'b1; br_id = 2'd2;
    drive_push(mk(8'h44, OPC_OP), 1, 1, 1, 1, 4'b0100);
    br_kill = 1'b0;
    check("t4_push_killed", count, 0);
    br_resolve = 1'b1; br_id = 2'd1;
    drive_push(mk(8'h45, OPC_OP), 1, 1, 1, 1, 4'b0010);
    br_resolve = 1'b0; br_kill = 1'b1;
    step();
    br_kill = 1'b0;
    check("t4_push_resolved", count, 1);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;

    // 5: load blocking
    drive_push(mk(8'h50, OPC_LOAD), 1, 1, 1, 1, 4'h0);
    drive_push(mk(8'h51, OPC_OP), 1, 1, 1, 1, 4'h0);
    block_loads = 1'b1;
    #1;
    check("t5_add_first", iss_payload, mk(8'h51, OPC_OP));
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    check("t5_lw_stays", count, 1);
    check("t5_lw_blocked", iss_valid, 0);
    block_loads = 1'b0;
    #1;
    check("t5_lw_issue", iss_payload, mk(8'h50, OPC_LOAD));
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    check("t5_count0", count, 0);

    // 6: duplicate CDB match on push, then flush with a concurrent push
    cdb_valid = 2'b11; cdb_tag[0 +: TAG_W] = 41'h9; cdb_tag[TAG_W +: TAG_W] = 41'h9;
    cdb_data[0 +: DATA_W] = 64'hAAAA; cdb_data[DATA_W +: DATA_W] = 64'hBBBB;
    drive_push(mk(8'h60, OPC_OP), 0, 64'h9, 1, 64'h1, 4'h0);
    cdb_valid = '0;
    #1;
    check("t6_dup_valid", iss_valid, 1);
    check("t6_dup_op1", iss_op1, 64'hAAAA);
    flush_all = 1'b1;
    in_payload = mk(8'h61, OPC_OP); in_op1v = 1'b1; in_op2v = 1'b1; in_valid = 1'b1;
    #1;
    check("t6_flush_iss", iss_valid, 0);
    check("t6_flush_payload", iss_payload, 0);
    step();
    flush_all = 1'b0; in_valid = 1'b0;
    check("t6_flush_count", count, 0);
    check("t6_flush_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
